// File: rtl/xf100_ifu_fetch_ctrl.sv
// rtl/xf100_ifu_fetch_ctrl.sv - xf100 IFU fetch sequencer: single-outstanding ITCM fetch with one-entry output buffer
// Owns the fetch PC, drops stale responses across redirects, and halts on a fetch bus error.
module xf100_ifu_fetch_ctrl #(
  parameter int                 PC_SIZE    = 32,
  parameter int                 INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_i_redirect,
  input  logic [PC_SIZE-1:0]    ifu_i_redirect_pc,
  output logic                  itcm_o_req,
  output logic [PC_SIZE-1:0]    itcm_o_addr,
  input  logic                  itcm_i_gnt,
  input  logic                  itcm_i_rsp_valid,
  input  logic [INSTR_SIZE-1:0] itcm_i_rsp_rdata,
  input  logic                  itcm_i_rsp_err,
  output logic                  ifu_o_valid,
  output logic [INSTR_SIZE-1:0] ifu_o_instr,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_err,
  input  logic                  ifu_i_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [PC_SIZE-1:0] PC_STEP    = PC_SIZE'(4);
  localparam logic [PC_SIZE-1:0] ALIGN_MASK = ~PC_SIZE'(3);

  state_e                state_q, state_d;
  logic [PC_SIZE-1:0]    pc_q, pc_d;
  logic [PC_SIZE-1:0]    req_pc_q, req_pc_d;
  logic                  drop_q, drop_d;
  logic                  buf_vld_q, buf_vld_d;
  logic [INSTR_SIZE-1:0] buf_instr_q, buf_instr_d;
  logic [PC_SIZE-1:0]    buf_pc_q, buf_pc_d;
  logic                  buf_err_q, buf_err_d;
  logic                  pop;

  // Only request when the buffer is guaranteed free by the time the response lands.
  assign itcm_o_req  = (state_q == S_REQ) && !ifu_i_redirect && (!buf_vld_q || ifu_i_ready);
  assign itcm_o_addr = pc_q;
  assign ifu_o_valid = buf_vld_q && !ifu_i_redirect;
  assign ifu_o_instr = buf_instr_q;
  assign ifu_o_pc    = buf_pc_q;
  assign ifu_o_err   = buf_err_q;
  assign pop         = ifu_o_valid && ifu_i_ready;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    buf_vld_d   = buf_vld_q && !pop;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_err_d   = buf_err_q;

    if (ifu_i_redirect) begin
      pc_d      = ifu_i_redirect_pc & ALIGN_MASK;
      buf_vld_d = 1'b0;
      if (state_q == S_WAIT && !itcm_i_rsp_valid) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = S_REQ;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (itcm_o_req && itcm_i_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_STEP;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (itcm_i_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else begin
              buf_vld_d   = 1'b1;
              buf_instr_d = itcm_i_rsp_rdata;
              buf_pc_d    = req_pc_q;
              buf_err_d   = itcm_i_rsp_err;
              state_d     = itcm_i_rsp_err ? S_HALT : S_REQ;
            end
          end
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      drop_q      <= 1'b0;
      buf_vld_q   <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      buf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      buf_vld_q   <= buf_vld_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_err_q   <= buf_err_d;
    end
  end

endmodule

// File: tb/tb_xf100_ifu_fetch_ctrl.sv
// tb/tb_xf100_ifu_fetch_ctrl.sv - self-checking bench for xf100_ifu_fetch_ctrl
// Directed scenarios plus a randomized run against a transaction-level fetch model.
module tb_xf100_ifu_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] opc;
  logic        oerr;
  logic        ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } ent_t;

  xf100_ifu_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ifu_i_redirect    (redirect),
    .ifu_i_redirect_pc (redirect_pc),
    .itcm_o_req        (req),
    .itcm_o_addr       (addr),
    .itcm_i_gnt        (gnt),
    .itcm_i_rsp_valid  (rsp_valid),
    .itcm_i_rsp_rdata  (rdata),
    .itcm_i_rsp_err    (rsp_err),
    .ifu_o_valid       (valid),
    .ifu_o_instr       (instr),
    .ifu_o_pc          (opc),
    .ifu_o_err         (oerr),
    .ifu_i_ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
    rsp_valid = 1'b0; rdata = '0; rsp_err = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL reset_req got %b exp 1", req); end
    checks++; if (addr !== 32'h8000_0000) begin errors++; $display("FAIL reset_addr got %h exp 80000000", addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (opc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", opc); end
    checks++; if (oerr !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", oerr); end
  endtask

  task automatic test_stream();
    logic [31:0] prev_data, prev_pc, a, d;
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    prev_data = '0; prev_pc = '0;
    for (int i = 0; i < 6; i++) begin
      a = 32'h8000_0000 + 32'(4 * i);
      #1;
      checks++; if (req !== 1'b1 || addr !== a) begin errors++; $display("FAIL stream_req got %b/%h exp 1/%h", req, addr, a); end
      if (i > 0) begin
        checks++;
        if (valid !== 1'b1 || opc !== prev_pc || instr !== prev_data) begin
          errors++; $display("FAIL stream_out got %b/%h/%h exp 1/%h/%h", valid, opc, instr, prev_pc, prev_data);
        end
      end
      tick();
      d = $urandom; rsp_valid = 1'b1; rdata = d;
      #1;
      checks++; if (valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL stream_rsp_cycle got valid %b req %b exp 0 0", valid, req); end
      tick();
      rsp_valid = 1'b0; prev_data = d; prev_pc = a;
    end
    gnt = 1'b0;
    #1;
    checks++; if (valid !== 1'b1 || opc !== prev_pc) begin errors++; $display("FAIL stream_last got %b/%h exp 1/%h", valid, opc, prev_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    tick();
    d = $urandom; rsp_valid = 1'b1; rdata = d;
    tick();
    rsp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req got %b exp 0", req); end
      checks++;
      if (valid !== 1'b1 || opc !== 32'h8000_0000 || instr !== d) begin
        errors++; $display("FAIL bp_hold got %b/%h/%h exp 1/80000000/%h", valid, opc, instr, d);
      end
      tick();
    end
    ready = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h8000_0004) begin errors++; $display("FAIL bp_release got %b/%h exp 1/80000004", req, addr); end
    tick();
    gnt = 1'b0;
  endtask

  task automatic test_redirect_wait();
    logic [31:0] d;
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    tick();
    gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL rw_redirect_cycle got %b/%b exp 0/0", valid, req); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rw_wait_req got %b exp 0", req); end
    tick();
    rsp_valid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rw_dropped got valid %b exp 0", valid); end
    checks++; if (req !== 1'b1 || addr !== 32'h0000_0100) begin errors++; $display("FAIL rw_newreq got %b/%h exp 1/00000100", req, addr); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0; d = $urandom; rsp_valid = 1'b1; rdata = d;
    tick();
    rsp_valid = 1'b0;
    #1;
    checks++; if (valid !== 1'b1 || opc !== 32'h0000_0100 || instr !== d) begin errors++; $display("FAIL rw_out got %b/%h/%h exp 1/00000100/%h", valid, opc, instr, d); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    tick();
    gnt = 1'b0; rsp_valid = 1'b1; rdata = 32'h1234_5678; redirect = 1'b1; redirect_pc = 32'h0000_0400;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_valid got %b exp 0", valid); end
    tick();
    rsp_valid = 1'b0; redirect = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rr_discard got valid %b exp 0", valid); end
    checks++; if (req !== 1'b1 || addr !== 32'h0000_0400) begin errors++; $display("FAIL rr_newreq got %b/%h exp 1/00000400", req, addr); end
  endtask

  task automatic test_error_halt();
    logic [31:0] e;
    do_reset();
    gnt = 1'b1; ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      rsp_valid = 1'b1; rdata = $urandom;
      tick();
      rsp_valid = 1'b0;
    end
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h8000_0008) begin errors++; $display("FAIL eh_req got %b/%h exp 1/80000008", req, addr); end
    tick();
    e = $urandom; rsp_valid = 1'b1; rdata = e; rsp_err = 1'b1;
    tick();
    rsp_valid = 1'b0; rsp_err = 1'b0; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL eh_halt_req got %b exp 0", req); end
      checks++;
      if (valid !== 1'b1 || oerr !== 1'b1 || opc !== 32'h8000_0008 || instr !== e) begin
        errors++; $display("FAIL eh_entry got %b/%b/%h/%h exp 1/1/80000008/%h", valid, oerr, opc, instr, e);
      end
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    checks++; if (valid !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL eh_redirect_cycle got %b/%b exp 0/0", valid, req); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0000_0200 || valid !== 1'b0) begin errors++; $display("FAIL eh_resume got %b/%h/%b exp 1/00000200/0", req, addr, valid); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0; gnt = 1'b1; ready = 1'b1;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", req, addr); end
    tick();
    rsp_valid = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    rsp_valid = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_next got %b/%h exp 1/00000000", req, addr); end
    checks++; if (valid !== 1'b1 || opc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_out got %b/%h exp 1/fffffffc", valid, opc); end
    gnt = 1'b0;
    tick();
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        h;
    logic [31:0] exp_pc, req_addr;
    logic        pending, stale, halted, exp_valid, exp_req;
    int          delay;
    do_reset();
    exp_pc = 32'h8000_0000; req_addr = '0;
    pending = 1'b0; stale = 1'b0; halted = 1'b0; delay = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redirect    = ($urandom_range(0, 99) < 6);
      redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      ready       = ($urandom_range(0, 99) < 70);
      gnt         = ($urandom_range(0, 99) < 60);
      rsp_valid   = 1'b0;
      rdata       = $urandom;
      rsp_err     = ($urandom_range(0, 99) < 8);
      if (pending) begin
        if (delay <= 1) rsp_valid = 1'b1;
        else delay--;
      end
      #1;
      exp_valid = (q.size() != 0) && !redirect;
      exp_req   = !pending && !halted && !redirect && (q.size() == 0 || ready);
      checks++; if (valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, valid, exp_valid); end
      checks++; if (req !== exp_req) begin errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, req, exp_req); end
      if (exp_req) begin
        checks++; if (addr !== exp_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", cyc, addr, exp_pc); end
      end
      if (exp_valid) begin
        h = q[0];
        checks++;
        if (instr !== h.instr || opc !== h.pc || oerr !== h.err) begin
          errors++; $display("FAIL rnd_entry cyc %0d got %h/%h/%b exp %h/%h/%b", cyc, instr, opc, oerr, h.instr, h.pc, h.err);
        end
      end
      if (redirect) begin
        q.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        halted = 1'b0;
        if (pending) begin
          if (rsp_valid) pending = 1'b0;
          else stale = 1'b1;
        end
      end else begin
        if (exp_valid && ready) void'(q.pop_front());
        if (exp_req && gnt) begin
          pending  = 1'b1;
          stale    = 1'b0;
          delay    = $urandom_range(1, 3);
          req_addr = exp_pc;
          exp_pc   = exp_pc + 32'd4;
        end else if (pending && rsp_valid) begin
          pending = 1'b0;
          if (stale) stale = 1'b0;
          else begin
            q.push_back('{instr: rdata, pc: req_addr, err: rsp_err});
            if (rsp_err) halted = 1'b1;
          end
        end
      end
      tick();
    end
    redirect = 1'b0; gnt = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rsp();
    test_error_halt();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xf100_ifu_fetch_ctrl.md
# xf100_ifu_fetch_ctrl

Instruction-fetch sequencer for the xf100 IFU. It owns the fetch PC, issues single-outstanding word requests to the instruction TCM, and buffers one returned instruction for the downstream stage behind a valid/ready handshake. It also handles pipeline redirects by dropping stale responses and flushing the buffer. It sits between the IFU top and the ITCM, and drives `ifu_o_instr`/`ifu_o_pc` into the decode path.

## Interface
- `PC_SIZE`, 32, fetch address width
- `INSTR_SIZE`, 32, instruction width
- `RESET_PC`, 32'h8000_0000, first fetch address after reset

- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `ifu_i_redirect`  in  1  redirect strobe, one cycle
- `ifu_i_redirect_pc`  in  PC_SIZE  new fetch address; bits [1:0] ignored and treated as 0
- `itcm_o_req`  out  1  fetch request valid
- `itcm_o_addr`  out  PC_SIZE  word-aligned fetch address
- `itcm_i_gnt`  in  1  request accepted this cycle
- `itcm_i_rsp_valid`  in  1  response valid; at most one per grant, earliest 1 cycle after the grant
- `itcm_i_rsp_rdata`  in  INSTR_SIZE  response data
- `itcm_i_rsp_err`  in  1  response bus error
- `ifu_o_valid`  out  1  buffered instruction valid
- `ifu_o_instr`  out  INSTR_SIZE  buffered instruction
- `ifu_o_pc`  out  PC_SIZE  address of the buffered instruction
- `ifu_o_err`  out  1  buffered entry carries a fetch error
- `ifu_i_ready`  in  1  downstream accepts the buffered entry

## Operation
- Registers:
  - `pc`: next fetch address.
  - `req_pc`: address of the outstanding request.
  - `state`: REQ, WAIT or HALT.
  - `drop`: discard the next response.
  - One-entry buffer: `buf_vld`, instr, pc, err.
- Reset values:
  - `pc` = RESET_PC, `state` = REQ, `drop` = 0, `buf_vld` = 0.
  - Buffer instr, pc and err = 0, so `ifu_o_instr`, `ifu_o_pc` and `ifu_o_err` reset to 0.
  - `itcm_o_addr` = `pc`, so it reads RESET_PC.
- `itcm_o_req` = (state==REQ) & !ifu_i_redirect & (!buf_vld | ifu_i_ready).
  - Because of this term, a request is never issued unless the buffer will be empty by the time its response can arrive.
- `itcm_o_addr` = `pc` (combinational).
- REQ state:
  - On `itcm_o_req & itcm_i_gnt`: `req_pc` <= `pc`, `pc` <= `pc`+4 (modulo 2^PC_SIZE), go to WAIT.
  - Otherwise hold.
- WAIT state, on `itcm_i_rsp_valid`:
  - If `drop`=1: discard the data, clear `drop`, go to REQ.
  - Else if `itcm_i_rsp_err`=0: load the buffer {rdata, `req_pc`, err=0}, go to REQ.
  - Else (`itcm_i_rsp_err`=1): load the buffer {rdata, `req_pc`, err=1}, go to HALT.
- HALT state: no requests are issued. Only a redirect leaves HALT.
- `ifu_o_valid` = `buf_vld` & !ifu_i_redirect.
- Handshake: `ifu_o_valid & ifu_i_ready` pops the buffer. In the same cycle it may be refilled by a response.
- Redirect, any state:
  - `pc` <= {redirect_pc[PC_SIZE-1:2], 2'b00}; `buf_vld` <= 0.
  - REQ or HALT: go to REQ.
  - WAIT without a response this cycle: `drop` <= 1, stay in WAIT.
  - WAIT with a response this cycle: discard the response, go to REQ.
- Redirect precedence:
  - Redirect overrides buffer load, pop, and error-to-HALT in the same cycle.
  - Redirect during a WAIT that already has `drop`=1 keeps `drop`=1 and keeps the newest PC.

## Timing
- Fetch latency: request in cycle N, grant in N, response in N+k (k≥1), `ifu_o_valid` high from N+k+1.
- Throughput, with k=1 and `ifu_i_ready` held high: one instruction every 2 cycles.
- Redirect in cycle R: the first request to the new PC is in cycle R+1 (from REQ/HALT), or in the cycle after the stale response is dropped (from WAIT).
- `ifu_o_valid` drops in the redirect cycle itself. This is a combinational path from `ifu_i_redirect`.
- PC wrap: `pc` = 2^PC_SIZE−4 is followed by 0, with no flag.
- Buffer full and `ifu_i_ready`=0: `itcm_o_req` stays low, so no backpressure into the ITCM response path.
- Reset mid-transaction: all state clears immediately. After reset, the ITCM is responsible for suppressing any in-flight response.

## Test plan
- Reset, then gnt always 1, rsp k=1, ready=1 → requests to 0x8000_0000, 0x8000_0004, …; each `ifu_o_pc` matches its address; one valid every 2 cycles.
- Ready held 0 after the first response → `itcm_o_req` stays 0 and the buffer holds 0x8000_0000. Ready goes 1 → a request to 0x8000_0004 issues in that same cycle.
- Redirect to 0x0000_0103 while in WAIT, response two cycles later → that response is dropped, next request to 0x0000_0100, next `ifu_o_pc`=0x0000_0100.
- Redirect in the same cycle as `rsp_valid` → response discarded, `ifu_o_valid`=0, request to the new PC on the next cycle.
- Response with err=1 at PC 0x8000_0008 → `ifu_o_err`=1, `ifu_o_pc`=0x8000_0008, no further `itcm_o_req`. Redirect to 0x200 → fetch resumes at 0x200.
- `RESET_PC`=32'hFFFF_FFFC → second request address is 0x0000_0000.
